// File: rtl/llm_page_writer.sv
// llm_page_writer: writes an srdy/drdy packet stream into linked pages with no extra latency, then emits one {head,length} descriptor per packet.
// Input stalls while there is no spare page or a link/descriptor is pending. Optional stat counters: LLM_PAGE_WRITER_STATS_EN.
module llm_page_writer #(
   parameter int lpsz  = 8,
   parameter int lpdsz = lpsz + 1,
   parameter int wpsz  = 2,
   parameter int width = 32,
   parameter int lensz = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  c_srdy,
   output logic                  c_drdy,
   input  logic [width-1:0]      c_data,
   input  logic                  c_eop,
   output logic                  pgreq,
   input  logic                  pgack,
   input  logic                  lprq_srdy,
   output logic                  lprq_drdy,
   input  logic [lpsz-1:0]       lprq_page,
   output logic                  lnp_srdy,
   input  logic                  lnp_drdy,
   output logic [lpsz+lpdsz-1:0] lnp_pnp,
   output logic                  pbuf_wr_en,
   output logic [lpsz+wpsz-1:0]  pbuf_wr_addr,
   output logic [width-1:0]      pbuf_wr_data,
`ifdef LLM_PAGE_WRITER_STATS_EN
   output logic [31:0]           stat_pkts,
   output logic [31:0]           stat_pages,
`endif
   output logic                  desc_srdy,
   input  logic                  desc_drdy,
   output logic [lpsz+lensz-1:0] desc_data
);

   localparam int WPP = 1 << wpsz;
   localparam int LDW = lpdsz - 1;
   localparam logic [wpsz-1:0]  OFF_LAST = wpsz'(WPP - 1);
   localparam logic [lensz-1:0] LEN_MAX  = '1;

   localparam logic [1:0] F_REQ  = 2'd0;
   localparam logic [1:0] F_WAIT = 2'd1;
   localparam logic [1:0] F_HELD = 2'd2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_BODY = 3'd1;
   localparam logic [2:0] S_LINK = 3'd2;
   localparam logic [2:0] S_TERM = 3'd3;
   localparam logic [2:0] S_DESC = 3'd4;

   logic [1:0]       fst_q, fst_d;
   logic [2:0]       mst_q, mst_d;
   logic [lpsz-1:0]  spare_q, spare_d;
   logic             spare_vld_q, spare_vld_d;
   logic [lpsz-1:0]  cur_q, cur_d;
   logic [lpsz-1:0]  head_q, head_d;
   logic [wpsz-1:0]  off_q, off_d;
   logic [lensz-1:0] len_q, len_d;

   logic             accept;
   logic             link_hs;
   logic             consume;
   logic             load;
   logic [wpsz-1:0]  wr_off;
   logic [lpsz-1:0]  wr_page;
   logic [lensz-1:0] len_inc;

   // The first word of a packet lands in the spare page before it is registered as cur.
   assign wr_off  = (mst_q == S_IDLE) ? '0 : off_q;
   assign wr_page = (mst_q == S_IDLE) ? spare_q : cur_q;
   assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

   assign c_drdy    = ((mst_q == S_IDLE) & spare_vld_q) | (mst_q == S_BODY);
   assign accept    = c_srdy & c_drdy;
   assign link_hs   = (mst_q == S_LINK) & spare_vld_q & lnp_drdy;
   assign consume   = ((mst_q == S_IDLE) & accept) | link_hs;
   assign load      = (fst_q == F_WAIT) & lprq_srdy;

   assign pgreq     = (fst_q == F_REQ) & ~spare_vld_q & ~reset;
   assign lprq_drdy = (fst_q == F_WAIT);

   assign pbuf_wr_en   = accept;
   assign pbuf_wr_addr = {wr_page, wr_off};
   assign pbuf_wr_data = c_data;

   assign desc_srdy = (mst_q == S_DESC);
   assign desc_data = {head_q, len_q};

   always_comb begin
      lnp_srdy = 1'b0;
      lnp_pnp  = '0;
      if (mst_q == S_LINK) begin
         lnp_srdy = spare_vld_q;
         lnp_pnp  = {cur_q, 1'b0, LDW'(spare_q)};
      end else if (mst_q == S_TERM) begin
         lnp_srdy = 1'b1;
         lnp_pnp  = {cur_q, 1'b1, LDW'(off_q)};
      end
   end

   always_comb begin
      fst_d       = fst_q;
      spare_d     = load ? lprq_page : spare_q;
      spare_vld_d = consume ? 1'b0 : (load ? 1'b1 : spare_vld_q);
      case (fst_q)
         F_REQ:   if (pgreq && pgack) fst_d = F_WAIT;
         F_WAIT:  if (lprq_srdy) fst_d = F_HELD;
         F_HELD:  if (consume) fst_d = F_REQ;
         default: fst_d = F_REQ;
      endcase
   end

   always_comb begin
      mst_d  = mst_q;
      cur_d  = cur_q;
      head_d = head_q;
      off_d  = off_q;
      len_d  = len_q;
      case (mst_q)
         S_IDLE, S_BODY: begin
            if (accept) begin
               if (mst_q == S_IDLE) begin
                  cur_d  = spare_q;
                  head_d = spare_q;
                  len_d  = {{(lensz-1){1'b0}}, 1'b1};
               end else begin
                  len_d  = len_inc;
               end
               // On eop the offset is frozen so the terminal link can report the last slot.
               if (c_eop) begin
                  off_d = wr_off;
                  mst_d = S_TERM;
               end else begin
                  off_d = wr_off + 1'b1;
                  mst_d = (wr_off == OFF_LAST) ? S_LINK : S_BODY;
               end
            end
         end
         S_LINK: begin
            if (link_hs) begin
               cur_d = spare_q;
               off_d = '0;
               mst_d = S_BODY;
            end
         end
         S_TERM: if (lnp_drdy) mst_d = S_DESC;
         S_DESC: begin
            if (desc_drdy) begin
               len_d = '0;
               off_d = '0;
               mst_d = S_IDLE;
            end
         end
         default: mst_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fst_q       <= F_REQ;
         mst_q       <= S_IDLE;
         spare_q     <= '0;
         spare_vld_q <= 1'b0;
         cur_q       <= '0;
         head_q      <= '0;
         off_q       <= '0;
         len_q       <= '0;
      end else begin
         fst_q       <= fst_d;
         mst_q       <= mst_d;
         spare_q     <= spare_d;
         spare_vld_q <= spare_vld_d;
         cur_q       <= cur_d;
         head_q      <= head_d;
         off_q       <= off_d;
         len_q       <= len_d;
      end
   end

`ifdef LLM_PAGE_WRITER_STATS_EN
   logic [31:0] stat_pkts_q, stat_pages_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_pkts_q  <= '0;
         stat_pages_q <= '0;
      end else begin
         if (desc_srdy && desc_drdy) stat_pkts_q <= stat_pkts_q + 32'd1;
         if (consume) stat_pages_q <= stat_pages_q + 32'd1;
      end
   end

   assign stat_pkts  = stat_pkts_q;
   assign stat_pages = stat_pages_q;
`endif

endmodule

// File: tb/tb_llm_page_writer.sv
// Bench for llm_page_writer: random packets against a page-list reference model with a queue scoreboard,
// plus directed reset, page-stall and descriptor-stall scenarios.
module tb_llm_page_writer;

   localparam int LPSZ  = 8;
   localparam int LPDSZ = 9;
   localparam int WPSZ  = 2;
   localparam int WIDTH = 32;
   localparam int LENSZ = 16;
   localparam int WPP   = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  c_srdy, c_drdy, c_eop;
   logic [WIDTH-1:0]      c_data;
   logic                  pgreq, pgack;
   logic                  lprq_srdy, lprq_drdy;
   logic [LPSZ-1:0]       lprq_page;
   logic                  lnp_srdy, lnp_drdy;
   logic [LPSZ+LPDSZ-1:0] lnp_pnp;
   logic                  pbuf_wr_en;
   logic [LPSZ+WPSZ-1:0]  pbuf_wr_addr;
   logic [WIDTH-1:0]      pbuf_wr_data;
   logic                  desc_srdy, desc_drdy;
   logic [LPSZ+LENSZ-1:0] desc_data;
`ifdef LLM_PAGE_WRITER_STATS_EN
   logic [31:0]           stat_pkts, stat_pages;
`endif

   always #5 clk = ~clk;

   llm_page_writer #(.lpsz(LPSZ), .lpdsz(LPDSZ), .wpsz(WPSZ), .width(WIDTH), .lensz(LENSZ)) dut (
      .clk(clk), .reset(reset),
      .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
      .pgreq(pgreq), .pgack(pgack),
      .lprq_srdy(lprq_srdy), .lprq_drdy(lprq_drdy), .lprq_page(lprq_page),
      .lnp_srdy(lnp_srdy), .lnp_drdy(lnp_drdy), .lnp_pnp(lnp_pnp),
      .pbuf_wr_en(pbuf_wr_en), .pbuf_wr_addr(pbuf_wr_addr), .pbuf_wr_data(pbuf_wr_data),
`ifdef LLM_PAGE_WRITER_STATS_EN
      .stat_pkts(stat_pkts), .stat_pages(stat_pages),
`endif
      .desc_srdy(desc_srdy), .desc_drdy(desc_drdy), .desc_data(desc_data)
   );

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_wr[$];
   logic [63:0] exp_lnk[$];
   logic [63:0] exp_desc[$];
   logic [7:0]  pages[512];
   int pm_pi = 0;
   int exp_pi = 0;
   int pi_at_rst = 0;
   int pkts_sent = 0;
   int descs_seen = 0;
   int descs_since_rst = 0;
   bit stall_lprq = 1'b0;
   bit desc_hold = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event occurred, required none", name);
   endtask

   // Scoreboard monitor: every handshake seen must match the oldest model expectation.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (pbuf_wr_en) begin
               if (exp_wr.size() == 0) bad("wr_unexpected");
               else chk("pbuf_write", 64'({pbuf_wr_addr, pbuf_wr_data}), exp_wr.pop_front());
            end
            if (lnp_srdy && lnp_drdy) begin
               if (exp_lnk.size() == 0) bad("lnp_unexpected");
               else chk("lnp_pnp", 64'(lnp_pnp), exp_lnk.pop_front());
            end
            if (desc_srdy && desc_drdy) begin
               descs_seen++;
               descs_since_rst++;
               if (exp_desc.size() == 0) bad("desc_unexpected");
               else chk("desc_data", 64'(desc_data), exp_desc.pop_front());
            end
         end
      end
   end

   // Page manager: one request at a time, hands out pages[] in order.
   initial begin : page_mgr
      int st;
      int dly;
      bit s_pgreq, s_ack, s_hs, s_rst;
      st = 0;
      dly = 0;
      pgack = 1'b0;
      lprq_srdy = 1'b0;
      lprq_page = '0;
      forever begin
         @(negedge clk);
         s_rst   = reset;
         s_pgreq = pgreq;
         s_ack   = pgreq && pgack;
         s_hs    = lprq_srdy && lprq_drdy;
         @(posedge clk);
         #1;
         if (s_rst) begin
            st = 0;
            pgack = 1'b0;
            lprq_srdy = 1'b0;
         end else begin
            case (st)
               0: if (s_pgreq && $urandom_range(0, 1) == 1) begin pgack = 1'b1; st = 1; end
               1: if (s_ack) begin pgack = 1'b0; dly = $urandom_range(0, 3); st = 2; end
               2: if (!stall_lprq) begin
                     if (dly == 0) begin
                        lprq_srdy = 1'b1;
                        lprq_page = pages[pm_pi];
                        st = 3;
                     end else dly--;
                  end
               default: if (s_hs) begin lprq_srdy = 1'b0; pm_pi++; st = 0; end
            endcase
         end
      end
   end

   initial begin : sink_drv
      lnp_drdy = 1'b0;
      desc_drdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         lnp_drdy  = ($urandom_range(0, 3) != 0);
         desc_drdy = desc_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
      end
   end

   initial begin : watchdog
      #400000;
      errors++;
      $display("FAIL watchdog: simulation still running, required finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic send_word(input logic [WIDTH-1:0] d, input bit eop);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      c_srdy = 1'b1;
      c_data = d;
      c_eop  = eop;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = c_drdy;
         n++;
         @(posedge clk);
         #1;
      end
      if (!acc) bad("accept_timeout");
      c_srdy = 1'b0;
      c_eop  = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   // mode 1: hold lprq off while the packet waits to link; mode 2: check the previous descriptor holds.
   task automatic send_pkt(input int n, input int mode);
      logic [WIDTH-1:0] dq[$];
      logic [63:0] prev_desc;
      logic [WIDTH-1:0] d;
      int np, base, t;
      np = (n + WPP - 1) / WPP;
      base = exp_pi;
      prev_desc = (exp_desc.size() > 0) ? exp_desc[$] : 64'd0;
      for (int w = 0; w < n; w++) begin
         d = $urandom;
         dq.push_back(d);
         exp_wr.push_back(64'({pages[base + w / WPP], 2'(w % WPP), d}));
      end
      for (int p = 0; p < np - 1; p++)
         exp_lnk.push_back(64'({pages[base + p], 1'b0, pages[base + p + 1]}));
      exp_lnk.push_back(64'({pages[base + np - 1], 1'b1, 8'((n - 1) % WPP)}));
      exp_desc.push_back(64'({pages[base], 16'((n > 65535) ? 65535 : n)}));
      exp_pi += np;
      pkts_sent++;
      if (mode == 2) begin
         t = 0;
         @(negedge clk);
         while (!desc_srdy && t < 200) begin @(negedge clk); t++; end
         if (!desc_srdy) bad("desc_wait_timeout");
         @(posedge clk);
         #1;
         c_srdy = 1'b1;
         c_data = dq[0];
         c_eop  = (n == 1);
         repeat (5) begin
            @(negedge clk);
            chk("desc_hold_data", 64'(desc_data), prev_desc);
            chk("desc_hold_c_drdy_desc_srdy", 64'({c_drdy, desc_srdy}), 64'd1);
         end
         @(posedge clk);
         #1;
         desc_hold = 1'b0;
      end
      for (int w = 0; w < n; w++) begin
         if (mode == 1 && w == WPP) begin
            c_srdy = 1'b1;
            c_data = dq[w];
            c_eop  = (w == n - 1);
            repeat (10) begin
               @(negedge clk);
               chk("link_stall_c_drdy_lnp_srdy", 64'({c_drdy, lnp_srdy}), 64'd0);
            end
            @(posedge clk);
            #1;
            stall_lprq = 1'b0;
         end
         send_word(dq[w], (w == n - 1));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_wr.size() + exp_lnk.size() + exp_desc.size()) != 0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if ((exp_wr.size() + exp_lnk.size() + exp_desc.size()) != 0) bad("drain_timeout");
   endtask

   initial begin : main
      logic [WIDTH-1:0] d0, d1;
      reset  = 1'b1;
      c_srdy = 1'b0;
      c_data = '0;
      c_eop  = 1'b0;
      for (int i = 0; i < 512; i++) pages[i] = 8'($urandom);
      pages[0] = 8'd5;
      pages[1] = 8'd3;
      pages[2] = 8'd7;
      pages[3] = 8'd9;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 64'({pgreq, c_drdy, lprq_drdy, lnp_srdy, desc_srdy, pbuf_wr_en}), 64'd0);
      chk("reset_lnp_pnp", 64'(lnp_pnp), 64'd0);
      chk("reset_desc_data", 64'(desc_data), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("pgreq_after_reset", 64'(pgreq), 64'd1);
      @(posedge clk);
      #1;

      send_pkt(1, 0);
      send_pkt(4, 0);
      send_pkt(6, 0);
      drain();

      repeat (20) begin @(posedge clk); #1; end
      stall_lprq = 1'b1;
      send_pkt(6, 1);
      drain();

      desc_hold = 1'b1;
      send_pkt(1, 0);
      send_pkt(3, 2);
      drain();

      // Reset in the middle of a packet: only the two accepted writes are expected.
      repeat (20) begin @(posedge clk); #1; end
      d0 = $urandom;
      d1 = $urandom;
      exp_wr.push_back(64'({pages[exp_pi], 2'd0, d0}));
      exp_wr.push_back(64'({pages[exp_pi], 2'd1, d1}));
      send_word(d0, 1'b0);
      send_word(d1, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midpkt_reset_ctl", 64'({pgreq, c_drdy, lprq_drdy, lnp_srdy, desc_srdy, pbuf_wr_en}), 64'd0);
      chk("midpkt_reset_lnp_pnp", 64'(lnp_pnp), 64'd0);
      chk("midpkt_reset_desc_data", 64'(desc_data), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("pgreq_after_midpkt_reset", 64'(pgreq), 64'd1);
      exp_pi = pm_pi;
      pi_at_rst = pm_pi;
      descs_since_rst = 0;
      chk("midpkt_writes_seen", 64'(exp_wr.size()), 64'd0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 40; k++) send_pkt($urandom_range(1, 13), 0);
      drain();

      chk("desc_count", 64'(descs_seen), 64'(pkts_sent));
`ifdef LLM_PAGE_WRITER_STATS_EN
      chk("stat_pkts", 64'(stat_pkts), 64'(descs_since_rst));
      chk("stat_pages", 64'(stat_pages), 64'(exp_pi - pi_at_rst));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
